// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel debouncer (2-flop sync, stability counter, level, press/release pulses).
// Optional auto-repeat generator is compiled in when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_bank #(
  parameter int                  CHANNELS      = 4,
  parameter int                  CNT_W         = 9,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW    = {CHANNELS{1'b0}},
  parameter int                  REPEAT_DELAY  = 50_000_000,
  parameter int                  REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_state,
  output logic [CHANNELS-1:0] button_down,
  output logic [CHANNELS-1:0] button_up,
  output logic [CHANNELS-1:0] button_repeat,
  output logic                any_down
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_D = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_P = REP_W'(REPEAT_PERIOD);
`endif

  logic [CHANNELS-1:0] w_raw;

  assign w_raw    = button ^ ACTIVE_LOW;
  assign any_down = |button_down;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             r_sync0;
      logic             r_sync1;
      logic             r_state;
      logic             r_down;
      logic             r_up;
      logic [CNT_W-1:0] r_cnt;
      logic             w_mismatch;
      logic             w_accept;

      assign w_mismatch = r_sync1 ^ r_state;
      assign w_accept   = w_mismatch && (r_cnt == CNT_MAX);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync0 <= 1'b0;
          r_sync1 <= 1'b0;
          r_state <= 1'b0;
          r_down  <= 1'b0;
          r_up    <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync0 <= w_raw[gi];
          r_sync1 <= r_sync0;
          r_down  <= w_accept && !r_state;
          r_up    <= w_accept && r_state;
          if (w_accept) begin
            r_state <= ~r_state;
          end
          // Any break in the mismatch throws away the accumulated count.
          if (!w_mismatch || w_accept) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign button_state[gi] = r_state;
      assign button_down[gi]  = r_down;
      assign button_up[gi]    = r_up;

`ifdef DEBOUNCE_BANK_REPEAT_EN
      logic [REP_W-1:0] r_hold;
      logic             r_rep_armed;
      logic             r_repeat;
      logic             w_state_next;
      logic [REP_W-1:0] w_hold_inc;
      logic [REP_W-1:0] w_target;
      logic             w_hit;

      assign w_state_next = r_state ^ w_accept;
      assign w_hold_inc   = r_hold + REP_W'(1);
      assign w_target     = r_rep_armed ? REP_P : REP_D;
      // Requiring the old state high keeps repeats off the press edge; the next state kills them on release.
      assign w_hit        = r_state && w_state_next && (w_hold_inc == w_target);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hold      <= '0;
          r_rep_armed <= 1'b0;
          r_repeat    <= 1'b0;
        end else if (!r_state) begin
          r_hold      <= '0;
          r_rep_armed <= 1'b0;
          r_repeat    <= 1'b0;
        end else begin
          r_repeat <= w_hit;
          if (w_hit) begin
            r_hold      <= '0;
            r_rep_armed <= 1'b1;
          end else begin
            r_hold <= w_hold_inc;
          end
        end
      end

      assign button_repeat[gi] = r_repeat;
`else
      assign button_repeat[gi] = 1'b0;
`endif
    end

`ifndef DEBOUNCE_BANK_REPEAT_EN
    // Repeat timing parameters stay referenced so both builds share one parameter list.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_idle
    end
`endif
  endgenerate

endmodule
